// File: rtl/board_line_clear.sv
// board_line_clear
// Line-clear sequencer for the board occupancy memory. After a start pulse it
// scans the rows from the bottom up and drops full rows. Surviving rows are
// copied down, the vacated top rows are zero-filled, and the number of lines
// removed is reported with a one-cycle done pulse.
//
// Ports
//   CLOCK_50      system clock
//   resetn        synchronous active-low reset
//   start         one-cycle request; honoured only while idle
//   busy          high from the cycle after an accepted start through DONE
//   done          one-cycle completion pulse
//   lines_cleared full rows removed by the last pass (held until next start)
//   board_rx/ry   read address (memory answers one cycle later)
//   board_rdata   registered read data
//   board_we      write enable, one cell per cycle
//   board_wx/wy   write address
//   board_wdata   write data
//
// state | meaning
// IDLE  | waiting for start, no memory activity
// CHECK | scan row src, AND all cells into full
// COPY  | move row src to row dst, cell by cell
// FILL  | zero rows count-1 .. 0
// DONE  | one-cycle completion pulse
`timescale 1ns/1ps
module board_line_clear #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [4:0] lines_cleared,
  output logic [3:0] board_rx,
  output logic [4:0] board_ry,
  input  logic       board_rdata,
  output logic       board_we,
  output logic [3:0] board_wx,
  output logic [4:0] board_wy,
  output logic       board_wdata
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_COPY, S_FILL, S_DONE} state_t;

  localparam logic [3:0] X_SCAN_LAST = 4'(COLS);
  localparam logic [3:0] X_FILL_LAST = 4'(COLS - 1);
  localparam logic [4:0] ROW_BOTTOM  = 5'(ROWS - 1);

  state_t     state, state_n;
  logic [4:0] src, src_n, dst, dst_n, count, count_n;
  logic [3:0] x, x_n;
  logic       full, full_n;
  logic [3:0] rx_q;
  logic [4:0] ry_q;
  logic       reading, row_full, fill_entry;
  logic [4:0] count_inc;

  // Read address is live only on the first COLS cycles of CHECK/COPY and
  // otherwise holds whatever was last presented.
  assign reading   = (state == S_CHECK || state == S_COPY) && (x < X_SCAN_LAST);
  assign board_rx  = reading ? x   : rx_q;
  assign board_ry  = reading ? src : ry_q;
  assign row_full  = full & board_rdata;
  assign count_inc = (count == 5'd31) ? count : count + 5'd1;
  assign lines_cleared = count;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= S_IDLE;
      src   <= '0;
      dst   <= '0;
      count <= '0;
      x     <= '0;
      full  <= 1'b1;
      rx_q  <= '0;
      ry_q  <= '0;
    end else begin
      state <= state_n;
      src   <= src_n;
      dst   <= dst_n;
      count <= count_n;
      x     <= x_n;
      full  <= full_n;
      rx_q  <= board_rx;
      ry_q  <= board_ry;
    end
  end

  always_comb begin
    state_n     = state;
    src_n       = src;
    dst_n       = dst;
    count_n     = count;
    x_n         = x;
    full_n      = full;
    fill_entry  = 1'b0;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    board_we    = 1'b0;
    board_wx    = '0;
    board_wy    = '0;
    board_wdata = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          src_n   = ROW_BOTTOM;
          dst_n   = ROW_BOTTOM;
          count_n = '0;
          x_n     = '0;
          full_n  = 1'b1;
          state_n = S_CHECK;
        end
      end

      S_CHECK: begin
        if (x != '0) full_n = row_full;
        if (x != X_SCAN_LAST) begin
          x_n = x + 4'd1;
        end else begin
          x_n    = '0;
          full_n = 1'b1;
          if (row_full) begin
            count_n = count_inc;
            if (src == '0) fill_entry = 1'b1;
            else           src_n = src - 5'd1;
          end else if (src == dst) begin
            if (src == '0) fill_entry = 1'b1;
            else begin
              src_n = src - 5'd1;
              dst_n = dst - 5'd1;
            end
          end else begin
            state_n = S_COPY;
          end
        end
      end

      S_COPY: begin
        // Data read on cycle k arrives on cycle k+1 and is written straight through.
        if (x != '0) begin
          board_we    = 1'b1;
          board_wx    = x - 4'd1;
          board_wy    = dst;
          board_wdata = board_rdata;
        end
        if (x != X_SCAN_LAST) begin
          x_n = x + 4'd1;
        end else begin
          x_n    = '0;
          full_n = 1'b1;
          if (src == '0) fill_entry = 1'b1;
          else begin
            src_n   = src - 5'd1;
            dst_n   = dst - 5'd1;
            state_n = S_CHECK;
          end
        end
      end

      S_FILL: begin
        // src is reused as the fill row pointer.
        board_we = 1'b1;
        board_wx = x;
        board_wy = src;
        if (x != X_FILL_LAST) begin
          x_n = x + 4'd1;
        end else begin
          x_n = '0;
          if (src == '0) state_n = S_DONE;
          else           src_n   = src - 5'd1;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase

    // Scan finished: zero the top count rows, or finish at once if none.
    if (fill_entry) begin
      x_n = '0;
      if (count_n == '0) state_n = S_DONE;
      else begin
        state_n = S_FILL;
        src_n   = count_n - 5'd1;
      end
    end
  end

endmodule
